// File: rtl/anton_neopixel_scheduler.sv
// anton_neopixel_scheduler: queues pixel writes from a host port (and optionally
// a whole-strip fill engine) and drains them to a NeoPixel driver only while the
// driver sits in its reset/latch window, so a frame is never altered mid-transmission.
// Optional feature macro: FILL_ENGINE_EN adds the fill FSM and host/fill round-robin.
// Queue entries are {address, colour}; colour format is RRRBBBGG.

module anton_neopixel_scheduler #(
    parameter int PIXELS_MAX = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_BITS  = 2
) (
    input  logic                 clk10mhz_i,
    input  logic                 resetN_i,
    input  logic                 hostValid_i,
    output logic                 hostReady_o,
    input  logic [7:0]           hostAddr_i,
    input  logic [7:0]           hostData_i,
    input  logic                 fillStart_i,
    input  logic [7:0]           fillData_i,
    output logic                 fillBusy_o,
    input  logic                 neoState_i,
    output logic [7:0]           busAddr_o,
    output logic [7:0]           busData_o,
    output logic                 busWrite_o,
    output logic [FIFO_BITS:0]   fifoLevel_o,
    output logic                 errAddr_o
);

    localparam int LVL_W   = FIFO_BITS + 1;
    localparam int ENTRY_W = 16;

    logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
    logic [FIFO_BITS-1:0] wrPtr_q, wrPtr_d;
    logic [FIFO_BITS-1:0] rdPtr_q, rdPtr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 busWrite_q, busWrite_d;
    logic [7:0]           busAddr_q, busAddr_d;
    logic [7:0]           busData_q, busData_d;
    logic                 errAddr_q, errAddr_d;

    logic                 full;
    logic                 empty;
    logic                 addrOk;
    logic                 hostXfer;
    logic                 pushEn;
    logic                 popEn;
    logic                 fillGrant;
    logic                 hostTurnOk;
    logic [ENTRY_W-1:0]   fillEntry;
    logic [ENTRY_W-1:0]   pushEntry;
    logic [ENTRY_W-1:0]   popEntry;

    assign full        = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty       = (level_q == '0);
    assign addrOk      = (hostAddr_i < 8'(PIXELS_MAX));

    // The host is offered a slot whenever there is room and it is the host's turn;
    // an out-of-range address still handshakes but is dropped instead of queued.
    assign hostReady_o = resetN_i && !full && hostTurnOk;
    assign hostXfer    = hostValid_i && hostReady_o;
    assign pushEn      = (hostXfer && addrOk) || fillGrant;
    assign pushEntry   = fillGrant ? fillEntry : {hostAddr_i, hostData_i};

    // Draining is only allowed while the driver is latching.
    assign popEn       = neoState_i && !empty;
    assign popEntry    = mem_q[rdPtr_q];

`ifdef FILL_ENGINE_EN
    typedef enum logic {
        FILL_IDLE = 1'b0,
        FILL_RUN  = 1'b1
    } fillState_t;

    fillState_t fillState_q, fillState_d;
    logic [7:0] fillIdx_q, fillIdx_d;
    logic [7:0] fillColour_q, fillColour_d;
    logic       hostTurn_q, hostTurn_d;
    logic       fillReq;

    assign fillReq    = (fillState_q == FILL_RUN);
    assign hostTurnOk = !fillReq || hostTurn_q;
    assign fillGrant  = fillReq && resetN_i && !full && !hostXfer;
    assign fillEntry  = {fillIdx_q, fillColour_q};
    assign fillBusy_o = fillReq;

    // Fill engine state and round-robin pointer; the host owns the first contended slot.
    always_ff @(posedge clk10mhz_i) begin
        if (!resetN_i) begin
            fillState_q  <= FILL_IDLE;
            fillIdx_q    <= '0;
            fillColour_q <= '0;
            hostTurn_q   <= 1'b1;
        end else begin
            fillState_q  <= fillState_d;
            fillIdx_q    <= fillIdx_d;
            fillColour_q <= fillColour_d;
            hostTurn_q   <= hostTurn_d;
        end
    end

    // Fill sequencing plus turn flip whenever host and fill actually competed.
    always_comb begin
        fillState_d  = fillState_q;
        fillIdx_d    = fillIdx_q;
        fillColour_d = fillColour_q;
        hostTurn_d   = hostTurn_q;
        case (fillState_q)
            FILL_IDLE: begin
                if (fillStart_i) begin
                    fillColour_d = fillData_i;
                    fillIdx_d    = '0;
                    fillState_d  = FILL_RUN;
                end
            end
            FILL_RUN: begin
                if (fillGrant) begin
                    fillIdx_d = fillIdx_q + 8'd1;
                    if (fillIdx_q == 8'(PIXELS_MAX - 1)) begin
                        fillState_d = FILL_IDLE;
                    end
                end
            end
            default: fillState_d = FILL_IDLE;
        endcase
        if (fillReq && hostValid_i && !full) begin
            hostTurn_d = !hostTurn_q;
        end
    end
`else
    logic unusedFill;

    assign unusedFill = fillStart_i ^ (^fillData_i);
    assign hostTurnOk = 1'b1;
    assign fillGrant  = 1'b0;
    assign fillEntry  = '0;
    assign fillBusy_o = 1'b0;
`endif

    // Queue pointer and occupancy bookkeeping; pointers wrap naturally at FIFO_DEPTH.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (pushEn) begin
            wrPtr_d = wrPtr_q + FIFO_BITS'(1);
        end
        if (popEn) begin
            rdPtr_d = rdPtr_q + FIFO_BITS'(1);
        end
        level_d = level_q + LVL_W'(pushEn) - LVL_W'(popEn);
    end

    // Driver-side outputs: a pop becomes a write strobe one cycle later, data held otherwise.
    always_comb begin
        busWrite_d = popEn;
        busAddr_d  = busAddr_q;
        busData_d  = busData_q;
        if (popEn) begin
            busAddr_d = popEntry[15:8];
            busData_d = popEntry[7:0];
        end
        errAddr_d = hostXfer && !addrOk;
    end

    // Control registers, all cleared by the synchronous reset.
    always_ff @(posedge clk10mhz_i) begin
        if (!resetN_i) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            busWrite_q <= 1'b0;
            busAddr_q  <= '0;
            busData_q  <= '0;
            errAddr_q  <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            level_q    <= level_d;
            busWrite_q <= busWrite_d;
            busAddr_q  <= busAddr_d;
            busData_q  <= busData_d;
            errAddr_q  <= errAddr_d;
        end
    end

    // Queue storage; stale contents are harmless because the pointers define validity.
    always_ff @(posedge clk10mhz_i) begin
        if (pushEn) begin
            mem_q[wrPtr_q] <= pushEntry;
        end
    end

    assign busWrite_o  = busWrite_q;
    assign busAddr_o   = busAddr_q;
    assign busData_o   = busData_q;
    assign errAddr_o   = errAddr_q;
    assign fifoLevel_o = level_q;

endmodule

// File: doc/anton_neopixel_scheduler.md
ANTON_NEOPIXEL_SCHEDULER -- requirements
Module: anton_neopixel_scheduler

Interface
REQ-001 Parameter PIXELS_MAX, default 5, shall set the number of LEDs in the strip; legal pixel addresses are 0..PIXELS_MAX-1.
REQ-002 Parameter FIFO_DEPTH, default 4, shall set the write-queue depth.
REQ-003 Parameter FIFO_BITS, default 2, shall set the queue pointer width, with log2(FIFO_DEPTH) = FIFO_BITS.
REQ-004 clk10mhz  in  1  the single clock; every flop shall be on its rising edge.
REQ-005 resetN  in  1  synchronous, active-low reset.
REQ-006 hostValid  in  1  host write request.
REQ-007 hostReady  out  1  host write accepted this cycle.
REQ-008 hostAddr  in  8  host pixel address.
REQ-009 hostData  in  8  host pixel colour, RRRBBBGG.
REQ-010 fillStart  in  1  one-cycle pulse that starts a whole-strip fill.
REQ-011 fillData  in  8  fill colour, RRRBBBGG.
REQ-012 fillBusy  out  1  fill engine is running.
REQ-013 neoState  in  1  driver state: 1 means the driver is in its reset/latch window.
REQ-014 busAddr  out  8  driver write address.
REQ-015 busData  out  8  driver write data.
REQ-016 busWrite  out  1  driver write strobe.
REQ-017 fifoLevel  out  FIFO_BITS+1  number of queued entries.
REQ-018 errAddr  out  1  one-cycle pulse when a host address is out of range.

Function
REQ-019 A host transfer shall occur when hostValid and hostReady are both high in the same cycle; hostAddr and hostData shall be sampled in that cycle.
REQ-020 The block shall push at most one entry per cycle into the queue, and no entry when the queue is full.
REQ-021 Arbitration: when host and fill both request and the queue is not full, the grant shall alternate round-robin; after reset the host wins first.
REQ-022 hostReady shall be a combinational function of queue-not-full and the grant; it shall never be high when the queue is full.
REQ-023 A host transfer with hostAddr >= PIXELS_MAX shall complete the handshake, shall not be queued, and shall pulse errAddr the next cycle.
REQ-024 The fill FSM shall have two states:
- IDLE: fillStart latches fillData, clears fillIdx and moves to RUN.
- RUN: each granted cycle queues (fillIdx, colour) and increments fillIdx; the grant for fillIdx = PIXELS_MAX-1 returns the FSM to IDLE.
REQ-025 fillStart shall be ignored while in RUN; fillBusy shall be 1 exactly while in RUN.
REQ-026 Drain: a pop shall occur in any cycle where neoState = 1 and the queue is not empty; at most one pop per cycle.
REQ-027 Each pop shall drive registered busWrite = 1 with that entry's busAddr and busData in the following cycle, so pop-to-strobe latency is 1 cycle.
REQ-028 No pop shall occur while neoState = 0, so the displayed frame is never modified during transmission.
REQ-029 busAddr and busData shall hold their last written values when busWrite = 0.
REQ-030 A simultaneous push and pop shall leave fifoLevel unchanged.
REQ-031 The queue shall be FIFO-ordered; pointers shall wrap modulo FIFO_DEPTH.
REQ-032 fifoLevel shall saturate only by blocking pushes; it shall never exceed FIFO_DEPTH or go below 0.

Reset
REQ-033 When resetN = 0 at a clock edge:
- the queue is emptied and the fill FSM goes to IDLE;
- the round-robin pointer is reset so the host wins first;
- busWrite, busAddr, busData, errAddr, fillBusy and fifoLevel are 0;
- in-flight fill progress and queued entries are discarded.
REQ-034 While resetN = 0, hostReady shall be 0.

Configuration
REQ-035 With FILL_ENGINE_EN defined, the fill FSM and round-robin arbitration shall be present.
REQ-036 Without FILL_ENGINE_EN:
- fillStart and fillData are ignored;
- fillBusy is constant 0;
- the host is the only requester, so hostReady = queue not full.

Verification
REQ-037 neoState = 0; host writes (1,0xE0), (2,0x1C), (3,0x03), (4,0xFF) -> hostReady 1 each cycle, fifoLevel = 4, busWrite stays 0.
REQ-038 Queue full; hostValid held with (0,0x55) -> hostReady 0; raise neoState -> one pop per cycle, busWrite strobes in order 1,2,3,4, then (0,0x55) is accepted and written.
REQ-039 fillStart with fillData = 0x92 while hostValid streams address 0 -> grants alternate host, fill, host, ...; fill writes addresses 0..4 with 0x92 and fillBusy drops after the address-4 grant.
REQ-040 Host write (7,0x11) -> handshake completes, errAddr pulses 1 cycle, fifoLevel unchanged, no busWrite.
REQ-041 resetN = 0 for 1 cycle while in RUN with 3 entries queued -> the next cycle shows fifoLevel 0, fillBusy 0, busWrite 0, and no stale writes after neoState rises.
REQ-042 FILL_ENGINE_EN undefined; fillStart pulse -> fillBusy stays 0 and no entries are queued.
